// File: rtl/fir_sample_sequencer.sv
// Feeds a serial 40-tap FIR MAC: stores each accepted sample in a circular delay line, then streams the history newest-first.
// Latency: a sample accepted at edge t is presented as tap 0 in cycle t+1; a frame lasts TAPS cycles.
// Backpressure: InReady only in IDLE or on the TapLast cycle; a refused sample must be held by the upstream.
module fir_sample_sequencer #(
   parameter int TAPS   = 40,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 6
) (
   input  logic                     Clock,
   input  logic                     Rst,
   input  logic                     InValid,
   input  logic signed [DATA_W-1:0] InData,
   output logic                     InReady,
   output logic                     TapValid,
   output logic signed [DATA_W-1:0] TapData,
   output logic [IDX_W-1:0]         TapIndex,
   output logic                     TapFirst,
   output logic                     TapLast
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
   localparam logic [IDX_W:0]   TAPS_EXT = (IDX_W + 1)'(TAPS);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic signed [DATA_W-1:0] mem [TAPS];
   logic [IDX_W-1:0]         wp;
   logic [IDX_W-1:0]         base;
   logic [IDX_W-1:0]         k;
   logic                     at_last;
   logic                     accept;
   logic [IDX_W:0]           offset;
   logic [IDX_W:0]           rd_sum;
   logic [IDX_W-1:0]         rd_ptr;

   assign at_last  = (k == LAST_IDX);
   assign TapValid = (state == RUN);
   assign TapIndex = k;

   always_ff @(posedge Clock) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      InReady   = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            InReady = 1'b1;
            if (InValid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (at_last) begin
               InReady = 1'b1;
               if (!InValid) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      accept = InValid & InReady;
   end

   // Slot for tap k+1 is (base - (k+1)) mod TAPS; widened by one bit so base+TAPS cannot overflow.
   always_comb begin
      offset = {1'b0, k} + (IDX_W + 1)'(1);
      rd_sum = '0;
      if ({1'b0, base} >= offset) begin
         rd_sum = {1'b0, base} - offset;
      end else begin
         rd_sum = {1'b0, base} + TAPS_EXT - offset;
      end
      rd_ptr = rd_sum[IDX_W-1:0];
   end

   always_ff @(posedge Clock) begin
      if (Rst) begin
         for (int i = 0; i < TAPS; i++) begin
            mem[i] <= '0;
         end
         wp       <= '0;
         base     <= '0;
         k        <= '0;
         TapData  <= '0;
         TapFirst <= 1'b0;
         TapLast  <= 1'b0;
      end else if (accept) begin
         mem[wp]  <= InData;
         TapData  <= InData;
         k        <= '0;
         base     <= wp;
         wp       <= (wp == LAST_IDX) ? '0 : wp + IDX_W'(1);
         TapFirst <= 1'b1;
         TapLast  <= 1'b0;
      end else if ((state == RUN) && !at_last) begin
         k        <= k + IDX_W'(1);
         TapData  <= mem[rd_ptr];
         TapFirst <= 1'b0;
         TapLast  <= ((k + IDX_W'(1)) == LAST_IDX);
      end else begin
         TapFirst <= 1'b0;
         TapLast  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Directed phases with random data/valid, checked against a history-list model of the delay line.
module tb_fir_sample_sequencer;

   localparam int TAPS   = 40;
   localparam int DATA_W = 32;
   localparam int IDX_W  = 6;

   logic              Clock = 1'b0;
   logic              Rst;
   logic              InValid;
   logic [DATA_W-1:0] InData;
   logic              InReady;
   logic              TapValid;
   logic [DATA_W-1:0] TapData;
   logic [IDX_W-1:0]  TapIndex;
   logic              TapFirst;
   logic              TapLast;

   fir_sample_sequencer #(
      .TAPS  (TAPS),
      .DATA_W(DATA_W),
      .IDX_W (IDX_W)
   ) dut (
      .Clock   (Clock),
      .Rst     (Rst),
      .InValid (InValid),
      .InData  (InData),
      .InReady (InReady),
      .TapValid(TapValid),
      .TapData (TapData),
      .TapIndex(TapIndex),
      .TapFirst(TapFirst),
      .TapLast (TapLast)
   );

   always #5 Clock = ~Clock;

   int total = 0;
   int bad   = 0;

   // Model: every sample accepted since reset, plus the position within the current frame.
   logic [DATA_W-1:0] hist[$];
   int                pos   = -1;
   int                cur_n = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [DATA_W-1:0] d, output logic acc);
      logic              exp_rdy;
      int                idx;
      logic [DATA_W-1:0] exp_dat;
      Rst     = 1'b0;
      InValid = v;
      InData  = d;
      exp_rdy = (pos < 0) || (pos == TAPS - 1);
      chk("in_ready", InReady, exp_rdy);
      acc = v && exp_rdy;
      @(posedge Clock);
      #1;
      if (acc) begin
         hist.push_back(d);
         cur_n = hist.size() - 1;
         pos   = 0;
      end else if (pos >= 0 && pos < TAPS - 1) begin
         pos++;
      end else begin
         pos = -1;
      end
      chk("tap_valid", TapValid, pos >= 0);
      if (pos >= 0) begin
         idx     = cur_n - pos;
         exp_dat = (idx >= 0) ? hist[idx] : '0;
         chk("tap_data", TapData, exp_dat);
         chk("tap_index", TapIndex, pos);
         chk("tap_first", TapFirst, pos == 0);
         chk("tap_last", TapLast, pos == TAPS - 1);
      end
   endtask

   task automatic rstep(input logic v);
      Rst     = 1'b1;
      InValid = v;
      InData  = $urandom;
      @(posedge Clock);
      #1;
      hist.delete();
      pos = -1;
      chk("rst_in_ready", InReady, 1'b1);
      chk("rst_tap_valid", TapValid, 1'b0);
      chk("rst_tap_data", TapData, '0);
      chk("rst_tap_index", TapIndex, '0);
      chk("rst_tap_first", TapFirst, 1'b0);
      chk("rst_tap_last", TapLast, 1'b0);
   endtask

   initial begin
      logic              acc;
      logic [DATA_W-1:0] ramp;
      logic [DATA_W-1:0] pend;
      Rst     = 1'b1;
      InValid = 1'b0;
      InData  = '0;

      // Reset held with InValid high, then idle.
      repeat (3) rstep(1'b1);
      repeat (3) step(1'b0, '0, acc);

      // Single sample from reset: history behind it reads as zero.
      step(1'b1, 32'd655361, acc);
      repeat (TAPS + 3) step(1'b0, '0, acc);

      // Continuous ramp 1..45 with InValid held high, covers pointer wrap.
      rstep(1'b0);
      ramp = 1;
      for (int i = 0; i < 46 * TAPS && ramp <= 45; i++) begin
         step(1'b1, ramp, acc);
         if (acc) ramp++;
      end
      repeat (TAPS) step(1'b0, '0, acc);

      // Stall for 7 idle cycles, then resume with random data and random valid.
      repeat (7) step(1'b0, '0, acc);
      pend = $urandom;
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), pend, acc);
         if (acc) pend = $urandom;
      end

      // Mid-frame reset at tap 17.
      for (int i = 0; i < 2 * TAPS && pos != 0; i++) begin
         step(1'b1, pend, acc);
      end
      pend = $urandom;
      for (int i = 0; i < TAPS && pos != 17; i++) begin
         step(1'b0, '0, acc);
      end
      chk("reach_idx17", TapIndex, 17);
      rstep(1'b0);
      step(1'b1, 32'd9, acc);
      repeat (TAPS + 1) step(1'b0, '0, acc);

      // Long random run, valid mostly high, negative samples included.
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 3) != 0), pend, acc);
         if (acc) pend = $urandom;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
